// File: rtl/instruction_decode_pkg.sv
// Shared decode definitions: opcodes, control-group bit positions and the main decoder,
// reused by the later pipeline stages to pick apart the control groups.
package instruction_decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // writeBackControl = {regWrite, memToReg}
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;
    // memAccessControl = {branch, memRead, memWrite}
    localparam int MEM_BRANCH    = 2;
    localparam int MEM_MEM_READ  = 1;
    localparam int MEM_MEM_WRITE = 0;
    // calculationControl = {regDst, aluOp[1:0], aluSrc}
    localparam int EX_REG_DST    = 3;
    localparam int EX_ALU_OP_HI  = 2;
    localparam int EX_ALU_OP_LO  = 1;
    localparam int EX_ALU_SRC    = 0;

    typedef struct packed {
        logic [1:0] wb;
        logic [2:0] mem;
        logic [3:0] ex;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.wb[WB_REG_WRITE] = 1'b1;
                c.ex[EX_REG_DST]   = 1'b1;
                c.ex[EX_ALU_OP_HI] = 1'b1;
            end
            OP_LW: begin
                c.wb[WB_REG_WRITE]  = 1'b1;
                c.wb[WB_MEM_TO_REG] = 1'b1;
                c.mem[MEM_MEM_READ] = 1'b1;
                c.ex[EX_ALU_SRC]    = 1'b1;
            end
            OP_SW: begin
                c.mem[MEM_MEM_WRITE] = 1'b1;
                c.ex[EX_ALU_SRC]     = 1'b1;
            end
            OP_BEQ: begin
                c.mem[MEM_BRANCH]  = 1'b1;
                c.ex[EX_ALU_OP_LO] = 1'b1;
            end
            OP_ADDI: begin
                c.wb[WB_REG_WRITE] = 1'b1;
                c.ex[EX_ALU_SRC]   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32x32 register file: two asynchronous read ports with write-through bypass,
// one synchronous write port, r0 hardwired to zero.
module instruction_decode_register_file
    import instruction_decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);

    // r0 has no storage; reads of address 0 are forced to zero below.
    logic [31:0] regs_q [1:31];
    logic        write_en;

    assign write_en = we_i && (waddr_i != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = '0;
        if (raddr1_i != 5'd0) begin
            if (write_en && (waddr_i == raddr1_i)) begin
                rdata1_o = wdata_i;
            end else begin
                rdata1_o = regs_q[raddr1_i];
            end
        end
    end

    always_comb begin
        rdata2_o = '0;
        if (raddr2_i != 5'd0) begin
            if (write_en && (waddr_i == raddr2_i)) begin
                rdata2_o = wdata_i;
            end else begin
                rdata2_o = regs_q[raddr2_i];
            end
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: control decode, register file read, immediate sign extension and
// load-use hazard detection against the instruction issued in the previous cycle.
module instruction_decode
    import instruction_decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] programCounterIn,
    input  logic [31:0] instruction,
    input  logic [4:0]  writeRegister,
    input  logic [31:0] writeData,
    input  logic        regWrite,
    output logic [1:0]  writeBackControl,
    output logic [2:0]  memAccessControl,
    output logic [3:0]  calculationControl,
    output logic [31:0] programCounterOut,
    output logic [31:0] readData1,
    output logic [31:0] readData2,
    output logic [31:0] immediateOperand,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic        pcWrite,
    output logic        ifIdWrite
);

    logic [5:0] op_field;
    logic [4:0] rs_field;
    logic [4:0] rt_field;
    ctrl_t      dec_ctrl;
    logic       stall;

    logic       prev_mem_read_q, prev_mem_read_d;
    logic [4:0] prev_rt_q, prev_rt_d;

    assign op_field = instruction[31:26];
    assign rs_field = instruction[25:21];
    assign rt_field = instruction[20:16];

    assign dec_ctrl          = decode_ctrl(op_field);
    assign programCounterOut = programCounterIn;
    assign immediateOperand  = {{16{instruction[15]}}, instruction[15:0]};
    assign rt                = rt_field;
    assign rd                = instruction[15:11];

    instruction_decode_register_file u_register_file (
        .clk      (clk),
        .reset    (reset),
        .raddr1_i (rs_field),
        .raddr2_i (rt_field),
        .waddr_i  (writeRegister),
        .wdata_i  (writeData),
        .we_i     (regWrite),
        .rdata1_o (readData1),
        .rdata2_o (readData2)
    );

    assign stall = prev_mem_read_q && (prev_rt_q != 5'd0) &&
                   ((prev_rt_q == rs_field) || (prev_rt_q == rt_field));

    // A bubble issues memRead=0, so the following cycle can never stall again.
    always_comb begin
        writeBackControl   = dec_ctrl.wb;
        memAccessControl   = dec_ctrl.mem;
        calculationControl = dec_ctrl.ex;
        pcWrite            = 1'b1;
        ifIdWrite          = 1'b1;
        if (stall) begin
            writeBackControl   = '0;
            memAccessControl   = '0;
            calculationControl = '0;
            pcWrite            = 1'b0;
            ifIdWrite          = 1'b0;
        end
    end

    assign prev_mem_read_d = memAccessControl[MEM_MEM_READ];
    assign prev_rt_d       = rt_field;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_mem_read_q <= 1'b0;
            prev_rt_q       <= '0;
        end else begin
            prev_mem_read_q <= prev_mem_read_d;
            prev_rt_q       <= prev_rt_d;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed-vector bench for the ID stage with hand-computed expected values.
module tb_instruction_decode;

    logic        clk;
    logic        reset;
    logic [31:0] programCounterIn;
    logic [31:0] instruction;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        regWrite;
    logic [1:0]  writeBackControl;
    logic [2:0]  memAccessControl;
    logic [3:0]  calculationControl;
    logic [31:0] programCounterOut;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] immediateOperand;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        pcWrite;
    logic        ifIdWrite;

    int n_compared;
    int n_mismatched;

    instruction_decode dut (
        .clk                (clk),
        .reset              (reset),
        .programCounterIn   (programCounterIn),
        .instruction        (instruction),
        .writeRegister      (writeRegister),
        .writeData          (writeData),
        .regWrite           (regWrite),
        .writeBackControl   (writeBackControl),
        .memAccessControl   (memAccessControl),
        .calculationControl (calculationControl),
        .programCounterOut  (programCounterOut),
        .readData1          (readData1),
        .readData2          (readData2),
        .immediateOperand   (immediateOperand),
        .rt                 (rt),
        .rd                 (rd),
        .pcWrite            (pcWrite),
        .ifIdWrite          (ifIdWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end else begin
            $display("ok   %s: %08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ctrl_word();
        return {23'd0, writeBackControl, memAccessControl, calculationControl};
    endfunction

    // Control words as {WB, MEM, EX}.
    localparam logic [31:0] C_RTYPE = 32'b10_000_1100;
    localparam logic [31:0] C_LW    = 32'b11_010_0001;
    localparam logic [31:0] C_SW    = 32'b00_001_0001;
    localparam logic [31:0] C_BEQ   = 32'b00_100_0010;
    localparam logic [31:0] C_ADDI  = 32'b10_000_0001;

    initial begin
        n_compared       = 0;
        n_mismatched     = 0;
        reset            = 1'b1;
        programCounterIn = 32'h0000_0004;
        instruction      = 32'h0001_1000;
        writeRegister    = 5'd0;
        writeData        = 32'h0;
        regWrite         = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("reset_pcWrite", {31'd0, pcWrite}, 32'd1);
        check_eq("reset_ifIdWrite", {31'd0, ifIdWrite}, 32'd1);
        check_eq("reset_rd2", readData2, 32'h0);
        check_eq("reset_ctrl", ctrl_word(), C_RTYPE);

        // Writing r0 must be ignored, including the bypass path.
        regWrite      = 1'b1;
        writeRegister = 5'd0;
        writeData     = 32'hFFFF_FFFF;
        #1;
        check_eq("r0_bypass_rd1", readData1, 32'h0);
        tick();
        check_eq("r0_rd1", readData1, 32'h0);
        check_eq("r0_rd2_unwritten", readData2, 32'h0);
        check_eq("rtype_ctrl", ctrl_word(), C_RTYPE);
        check_eq("rt_field", {27'd0, rt}, 32'd1);
        check_eq("rd_field", {27'd0, rd}, 32'd2);

        // Write r1: bypass visible before the edge, stored value after.
        writeRegister = 5'd1;
        #1;
        check_eq("r1_bypass_rd2", readData2, 32'hFFFF_FFFF);
        tick();
        regWrite = 1'b0;
        #1;
        check_eq("r1_stored_rd2", readData2, 32'hFFFF_FFFF);

        regWrite      = 1'b1;
        writeRegister = 5'd3;
        writeData     = 32'h1234_5678;
        tick();
        regWrite = 1'b0;

        // Load-use: lw r3,4(r1) followed by add r4,r3,r1.
        instruction = 32'h8C23_0004;
        #1;
        check_eq("lw_ctrl", ctrl_word(), C_LW);
        check_eq("lw_pcWrite", {31'd0, pcWrite}, 32'd1);
        tick();
        instruction = 32'h0061_2020;
        #1;
        check_eq("stall_pcWrite", {31'd0, pcWrite}, 32'd0);
        check_eq("stall_ifIdWrite", {31'd0, ifIdWrite}, 32'd0);
        check_eq("stall_ctrl", ctrl_word(), 32'd0);
        check_eq("stall_rd1", readData1, 32'h1234_5678);
        tick();
        check_eq("after_stall_pcWrite", {31'd0, pcWrite}, 32'd1);
        check_eq("after_stall_ifIdWrite", {31'd0, ifIdWrite}, 32'd1);
        check_eq("after_stall_ctrl", ctrl_word(), C_RTYPE);

        // lw r5 followed by an instruction not touching r5: no stall.
        instruction = 32'h8C25_0004;
        tick();
        instruction = 32'h0022_1820;
        #1;
        check_eq("no_hazard_pcWrite", {31'd0, pcWrite}, 32'd1);
        check_eq("no_hazard_ctrl", ctrl_word(), C_RTYPE);

        // lw r0 followed by a use of r0: never a hazard.
        instruction = 32'h8C20_0004;
        tick();
        instruction = 32'h0000_1820;
        #1;
        check_eq("r0_hazard_pcWrite", {31'd0, pcWrite}, 32'd1);

        // Immediates, PC pass-through, remaining opcodes.
        programCounterIn = 32'h0000_0040;
        instruction      = 32'h2001_8001;
        #1;
        check_eq("imm_neg", immediateOperand, 32'hFFFF_8001);
        check_eq("addi_ctrl", ctrl_word(), C_ADDI);
        check_eq("pc_pass", programCounterOut, 32'h0000_0040);
        tick();
        instruction = 32'h2001_7FFF;
        #1;
        check_eq("imm_pos", immediateOperand, 32'h0000_7FFF);
        tick();
        instruction = 32'hAC01_0000;
        #1;
        check_eq("sw_ctrl", ctrl_word(), C_SW);
        tick();
        instruction = 32'h1001_0000;
        #1;
        check_eq("beq_ctrl", ctrl_word(), C_BEQ);
        tick();
        instruction = 32'hFC00_0000;
        #1;
        check_eq("unknown_ctrl", ctrl_word(), 32'd0);
        check_eq("unknown_pcWrite", {31'd0, pcWrite}, 32'd1);
        tick();

        // Reset with a pending hazard and a simultaneous write: reset wins on both.
        instruction = 32'h8C23_0004;
        tick();
        reset         = 1'b1;
        regWrite      = 1'b1;
        writeRegister = 5'd1;
        writeData     = 32'hAAAA_5555;
        instruction   = 32'h0061_2020;
        tick();
        reset    = 1'b0;
        regWrite = 1'b0;
        #1;
        check_eq("post_reset_pcWrite", {31'd0, pcWrite}, 32'd1);
        check_eq("post_reset_ctrl", ctrl_word(), C_RTYPE);
        check_eq("post_reset_r3", readData1, 32'h0);
        check_eq("post_reset_r1", readData2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
